demux1_4: RTL and testbench

Registered 1-to-4 demultiplexer, the counterpart of the team's 4:1 mux `mul`. It routes an incoming data word to one of four output channels a/b/c/d. The channel comes either from an external select or from an internal round-robin slot counter locked to a frame sync. It sits on the receive side of a 4-slot time-division link and rebuilds the four parallel channels plus a per-frame parallel word.

---
 rtl/demux1_4_if.sv | 42 ++++
 rtl/demux1_4.sv | 135 +++++++++++++
 tb/tb_demux1_4.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/demux1_4_if.sv
// demux1_4_if: bundles the data-side signals of the 1-to-4 demultiplexer.
//   master : drives din/din_valid/sync/auto_mode/s, observes channel and frame outputs
//   slave  : the demultiplexer itself
// Optional macro DEMUX_FRAME_CNT_EN adds the 16-bit frame_cnt signal.
interface demux1_4_if #(
  parameter int unsigned W = 1
);
  logic [W-1:0]   din;
  logic           din_valid;
  logic           sync;
  logic           auto_mode;
  logic [1:0]     s;
  logic [W-1:0]   a;
  logic [W-1:0]   b;
  logic [W-1:0]   c;
  logic [W-1:0]   d;
  logic [3:0]     ch_valid;
  logic [4*W-1:0] frame_out;
  logic           frame_done;
  logic           frame_err;
`ifdef DEMUX_FRAME_CNT_EN
  logic [15:0]    frame_cnt;

  modport master (
    output din, din_valid, sync, auto_mode, s,
    input  a, b, c, d, ch_valid, frame_out, frame_done, frame_err, frame_cnt
  );
  modport slave (
    input  din, din_valid, sync, auto_mode, s,
    output a, b, c, d, ch_valid, frame_out, frame_done, frame_err, frame_cnt
  );
`else
  modport master (
    output din, din_valid, sync, auto_mode, s,
    input  a, b, c, d, ch_valid, frame_out, frame_done, frame_err
  );
  modport slave (
    input  din, din_valid, sync, auto_mode, s,
    output a, b, c, d, ch_valid, frame_out, frame_done, frame_err
  );
`endif
endinterface

// File: rtl/demux1_4.sv
// demux1_4: registered 1-to-4 demultiplexer for the receive side of a 4-slot TDM link.
// Routes din to channel a/b/c/d either by external select s (manual) or by a round-robin
// slot counter locked to a frame sync (auto), and rebuilds a per-frame parallel word.
// Ports:
//   clk  : system clock, rising edge
//   rst  : synchronous reset, active-high
//   bus  : demux1_4_if.slave (din, din_valid, sync, auto_mode, s in;
//          a, b, c, d, ch_valid, frame_out, frame_done, frame_err out)
// Optional macro DEMUX_FRAME_CNT_EN adds bus.frame_cnt, a 16-bit count of completed frames.
module demux1_4 #(
  parameter int unsigned W = 1
) (
  input logic       clk,
  input logic       rst,
  demux1_4_if.slave bus
);

  typedef enum logic [0:0] {StIdle, StRun} state_e;

  state_e         state_q, state_d;
  logic [1:0]     slot_q, slot_d;
  logic [W-1:0]   ch_q [4];
  logic [W-1:0]   ch_d [4];
  logic [3:0]     ch_valid_q, ch_valid_d;
  logic [4*W-1:0] frame_out_q, frame_out_d;
  logic           frame_done_q, frame_done_d;
  logic           frame_err_q, frame_err_d;

  logic           wr_en;
  logic [1:0]     wr_sel;

  always_comb begin
    state_d      = state_q;
    slot_d       = slot_q;
    frame_out_d  = frame_out_q;
    frame_done_d = 1'b0;
    frame_err_d  = 1'b0;
    wr_en        = 1'b0;
    wr_sel       = 2'd0;

    if (!bus.auto_mode) begin
      // Manual mode keeps the frame tracker parked so re-entering auto waits for a sync.
      state_d = StIdle;
      slot_d  = 2'd0;
      wr_en   = bus.din_valid;
      wr_sel  = bus.s;
    end else if (bus.din_valid) begin
      unique case (state_q)
        StIdle: begin
          // Words before the first sync are dropped silently.
          if (bus.sync) begin
            wr_en   = 1'b1;
            wr_sel  = 2'd0;
            slot_d  = 2'd1;
            state_d = StRun;
          end
        end
        StRun: begin
          wr_en = 1'b1;
          if (bus.sync) begin
            // Sync always restarts the frame; mid-frame it abandons the partial frame.
            frame_err_d = (slot_q != 2'd0);
            wr_sel      = 2'd0;
            slot_d      = 2'd1;
          end else begin
            wr_sel = slot_q;
            slot_d = slot_q + 2'd1;
            if (slot_q == 2'd3) begin
              frame_done_d = 1'b1;
              frame_out_d  = {bus.din, ch_q[2], ch_q[1], ch_q[0]};
            end
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_comb begin
    for (int k = 0; k < 4; k++) begin
      ch_d[k]       = ch_q[k];
      ch_valid_d[k] = 1'b0;
    end
    if (wr_en) begin
      ch_d[wr_sel]       = bus.din;
      ch_valid_d[wr_sel] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      slot_q       <= 2'd0;
      for (int k = 0; k < 4; k++) ch_q[k] <= '0;
      ch_valid_q   <= 4'd0;
      frame_out_q  <= '0;
      frame_done_q <= 1'b0;
      frame_err_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      slot_q       <= slot_d;
      for (int k = 0; k < 4; k++) ch_q[k] <= ch_d[k];
      ch_valid_q   <= ch_valid_d;
      frame_out_q  <= frame_out_d;
      frame_done_q <= frame_done_d;
      frame_err_q  <= frame_err_d;
    end
  end

  assign bus.a          = ch_q[0];
  assign bus.b          = ch_q[1];
  assign bus.c          = ch_q[2];
  assign bus.d          = ch_q[3];
  assign bus.ch_valid   = ch_valid_q;
  assign bus.frame_out  = frame_out_q;
  assign bus.frame_done = frame_done_q;
  assign bus.frame_err  = frame_err_q;

`ifdef DEMUX_FRAME_CNT_EN
  logic [15:0] frame_cnt_q, frame_cnt_d;

  always_comb begin
    frame_cnt_d = frame_cnt_q;
    if (frame_done_d) frame_cnt_d = frame_cnt_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) frame_cnt_q <= 16'd0;
    else     frame_cnt_q <= frame_cnt_d;
  end

  assign bus.frame_cnt = frame_cnt_q;
`endif

endmodule

// File: tb/tb_demux1_4.sv
// tb_demux1_4: directed self-checking bench for demux1_4 with W=4.
module tb_demux1_4;
  localparam int unsigned W = 4;

  logic clk;
  logic rst;
  int   total;
  int   bad;

  demux1_4_if #(.W(W)) bus ();

  demux1_4 #(.W(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // Advance one clock and settle just after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic sy, input logic [W-1:0] dv);
    bus.din_valid = v;
    bus.sync      = sy;
    bus.din       = dv;
  endtask

  task automatic check_cnt(input string tag, input logic [15:0] exp);
`ifdef DEMUX_FRAME_CNT_EN
    check(tag, {16'd0, bus.frame_cnt}, {16'd0, exp});
`endif
  endtask

  initial begin
    total = 0;
    bad   = 0;

    // Reset with garbage on the inputs.
    rst = 1'b1;
    bus.auto_mode = 1'b1;
    bus.s = 2'd3;
    drive(1'b1, 1'b1, 4'hF);
    step();
    step();
    check("rst_abcd", {16'd0, bus.d, bus.c, bus.b, bus.a}, 32'h0);
    check("rst_chv", {28'd0, bus.ch_valid}, 32'h0);
    check("rst_fout", {16'd0, bus.frame_out}, 32'h0);
    check("rst_pulses", {30'd0, bus.frame_done, bus.frame_err}, 32'h0);
    check_cnt("rst_cnt", 16'd0);

    rst = 1'b0;
    drive(1'b0, 1'b1, 4'hF);
    step();
    step();
    step();
    check("idle_abcd", {16'd0, bus.d, bus.c, bus.b, bus.a}, 32'h0);
    check("idle_chv", {28'd0, bus.ch_valid}, 32'h0);

    // Manual routing.
    bus.auto_mode = 1'b0;
    bus.s = 2'd3;
    drive(1'b1, 1'b0, 4'h1);
    step();
    check("man_d", {28'd0, bus.d}, 32'h1);
    check("man_abc", {20'd0, bus.c, bus.b, bus.a}, 32'h0);
    check("man_chv_d", {28'd0, bus.ch_valid}, 32'h8);
    check("man_done0", {31'd0, bus.frame_done}, 32'h0);
    bus.s = 2'd0;
    drive(1'b0, 1'b0, 4'h7);
    step();
    check("man_gap_chv", {28'd0, bus.ch_valid}, 32'h0);
    drive(1'b1, 1'b1, 4'h1);
    step();
    check("man_a", {16'd0, bus.d, bus.c, bus.b, bus.a}, 32'h1001);
    check("man_chv_a", {28'd0, bus.ch_valid}, 32'h1);
    check("man_nopulse", {30'd0, bus.frame_done, bus.frame_err}, 32'h0);

    // Auto frame 1,2,3,4.
    bus.auto_mode = 1'b1;
    drive(1'b1, 1'b1, 4'h1);
    step();
    check("f1_chv0", {28'd0, bus.ch_valid}, 32'h1);
    drive(1'b1, 1'b0, 4'h2);
    step();
    check("f1_chv1", {28'd0, bus.ch_valid}, 32'h2);
    drive(1'b1, 1'b0, 4'h3);
    step();
    check("f1_chv2", {28'd0, bus.ch_valid}, 32'h4);
    check("f1_done_early", {31'd0, bus.frame_done}, 32'h0);
    drive(1'b1, 1'b0, 4'h4);
    step();
    check("f1_chv3", {28'd0, bus.ch_valid}, 32'h8);
    check("f1_done", {31'd0, bus.frame_done}, 32'h1);
    check("f1_fout", {16'd0, bus.frame_out}, 32'h4321);
    check("f1_abcd", {16'd0, bus.d, bus.c, bus.b, bus.a}, 32'h4321);
    check_cnt("f1_cnt", 16'd1);

    // Frame 5,6,gap,gap,7,8.
    drive(1'b1, 1'b1, 4'h5);
    step();
    check("f2_chv0", {28'd0, bus.ch_valid}, 32'h1);
    check("f2_pulses0", {30'd0, bus.frame_done, bus.frame_err}, 32'h0);
    drive(1'b1, 1'b0, 4'h6);
    step();
    drive(1'b0, 1'b0, 4'h0);
    step();
    check("f2_gap_chv", {28'd0, bus.ch_valid}, 32'h0);
    step();
    check("f2_gap_done", {31'd0, bus.frame_done}, 32'h0);
    drive(1'b1, 1'b0, 4'h7);
    step();
    check("f2_chv2", {28'd0, bus.ch_valid}, 32'h4);
    drive(1'b1, 1'b0, 4'h8);
    step();
    check("f2_done", {31'd0, bus.frame_done}, 32'h1);
    check("f2_fout", {16'd0, bus.frame_out}, 32'h8765);
    check_cnt("f2_cnt", 16'd2);

    // Mid-frame sync.
    drive(1'b1, 1'b1, 4'h9);
    step();
    check("mf_err0", {31'd0, bus.frame_err}, 32'h0);
    drive(1'b1, 1'b0, 4'hA);
    step();
    drive(1'b1, 1'b1, 4'hB);
    step();
    check("mf_err", {30'd0, bus.frame_done, bus.frame_err}, 32'h1);
    check("mf_a", {28'd0, bus.a}, 32'hB);
    check("mf_chv", {28'd0, bus.ch_valid}, 32'h1);
    check("mf_fout_hold", {16'd0, bus.frame_out}, 32'h8765);
    drive(1'b1, 1'b0, 4'hC);
    step();
    check("mf_err_clr", {31'd0, bus.frame_err}, 32'h0);
    drive(1'b1, 1'b0, 4'hD);
    step();
    drive(1'b1, 1'b0, 4'hE);
    step();
    check("mf_done", {30'd0, bus.frame_done, bus.frame_err}, 32'h2);
    check("mf_fout", {16'd0, bus.frame_out}, 32'hEDCB);
    check_cnt("mf_cnt", 16'd3);

    // Mode switch at slot 2, then back to auto.
    drive(1'b1, 1'b1, 4'h1);
    step();
    drive(1'b1, 1'b0, 4'h2);
    step();
    bus.auto_mode = 1'b0;
    bus.s = 2'd1;
    drive(1'b1, 1'b1, 4'h3);
    step();
    check("ms_man_b", {28'd0, bus.b}, 32'h3);
    check("ms_man_chv", {28'd0, bus.ch_valid}, 32'h2);
    check("ms_man_pulses", {30'd0, bus.frame_done, bus.frame_err}, 32'h0);
    bus.auto_mode = 1'b1;
    drive(1'b1, 1'b0, 4'h5);
    step();
    check("ms_drop1", {28'd0, bus.ch_valid}, 32'h0);
    drive(1'b1, 1'b0, 4'h6);
    step();
    check("ms_drop2", {28'd0, bus.ch_valid}, 32'h0);
    check("ms_hold", {16'd0, bus.d, bus.c, bus.b, bus.a}, 32'hED31);
    drive(1'b1, 1'b1, 4'h7);
    step();
    check("ms_sync_a", {28'd0, bus.a}, 32'h7);
    check("ms_sync_chv", {28'd0, bus.ch_valid}, 32'h1);
    check("ms_sync_err", {31'd0, bus.frame_err}, 32'h0);

    // Reset overrides a valid word.
    rst = 1'b1;
    drive(1'b1, 1'b0, 4'h9);
    step();
    check("rst2_abcd", {16'd0, bus.d, bus.c, bus.b, bus.a}, 32'h0);
    check("rst2_chv", {28'd0, bus.ch_valid}, 32'h0);
    check("rst2_fout", {16'd0, bus.frame_out}, 32'h0);
    check_cnt("rst2_cnt", 16'd0);
    rst = 1'b0;
    // After reset the tracker is idle: a word without sync is dropped.
    drive(1'b1, 1'b0, 4'h9);
    step();
    check("rst2_drop", {28'd0, bus.ch_valid}, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
